eth_tx: RTL and testbench

//  Ethernet frame transmitter; the transmit-side counterpart of eth_rx.

---
 rtl/eth_tx_if.sv | 25 ++
 rtl/eth_tx.sv | 234 +++++++++++++++++++++++
 tb/tb_eth_tx.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_if.sv
// Byte-stream bundle between a payload source / wire sink and the eth_tx framer.
// slave is the framer side; master is the source/sink side.
interface eth_tx_if;
  logic [7:0]  payload_byte;
  logic        payload_valid;
  logic        payload_last;
  logic        payload_ready;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_busy;
  logic        frame_done;
  logic        err_oversize;
  logic [31:0] frames_sent;

  modport master (
    output payload_byte, payload_valid, payload_last, tx_ready,
    input  payload_ready, tx_byte, tx_valid, tx_busy, frame_done, err_oversize, frames_sent
  );

  modport slave (
    input  payload_byte, payload_valid, payload_last, tx_ready,
    output payload_ready, tx_byte, tx_valid, tx_busy, frame_done, err_oversize, frames_sent
  );
endinterface

// File: rtl/eth_tx.sv
// Ethernet frame transmitter: wraps a payload byte stream with preamble, SFD,
// header, zero pad and FCS, then holds the line idle for the inter-frame gap.
module eth_tx #(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned IFG_CYCLES  = 12
) (
  input logic     clk,
  input logic     rst_n,
  eth_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam logic [111:0] HDR       = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [31:0]  CRC_POLY  = 32'hEDB8_8320;
  localparam logic [31:0]  CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [10:0]  MIN_L     = MIN_PAYLOAD[10:0];
  localparam logic [10:0]  MAX_L     = MAX_PAYLOAD[10:0];
  localparam logic [7:0]   IFG_LAST  = IFG_CYCLES[7:0] - 8'd1;

  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  state_t      r_state,   w_state;
  logic [3:0]  r_idx,     w_idx;
  logic [10:0] r_pay_cnt, w_pay_cnt;
  logic [7:0]  r_ifg_cnt, w_ifg_cnt;
  logic [31:0] r_crc,     w_crc;
  logic [7:0]  r_tx_byte, w_tx_byte;
  logic        r_tx_valid, w_tx_valid;
  logic        r_err,     w_err;
  logic [31:0] r_frames;
  logic        w_done;
  logic        w_pay_ready;
  logic        w_load_ok;
  logic [10:0] w_pay_inc;
  logic [6:0]  w_hdr_base;
  logic [4:0]  w_fcs_base;
  logic [31:0] w_fcs;
  logic [7:0]  w_hdr_byte;
  logic [7:0]  w_fcs_byte;

  // Next-state, byte loading and CRC update for every frame phase.
  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_pay_cnt   = r_pay_cnt;
    w_ifg_cnt   = r_ifg_cnt;
    w_crc       = r_crc;
    w_tx_byte   = r_tx_byte;
    w_tx_valid  = r_tx_valid & ~bus.tx_ready;
    w_err       = 1'b0;
    w_done      = 1'b0;
    w_pay_ready = 1'b0;
    w_load_ok   = ~r_tx_valid | bus.tx_ready;
    w_pay_inc   = r_pay_cnt + 11'd1;
    w_hdr_base  = {(4'd13 - r_idx), 3'b000};
    w_hdr_byte  = HDR[w_hdr_base +: 8];
    w_fcs       = ~r_crc;
    w_fcs_base  = {r_idx[1:0], 3'b000};
    w_fcs_byte  = w_fcs[w_fcs_base +: 8];

    case (r_state)
      S_IDLE: begin
        w_crc     = CRC_INIT;
        w_pay_cnt = 11'd0;
        if (bus.payload_valid && w_load_ok) begin
          w_tx_byte  = 8'h55;
          w_tx_valid = 1'b1;
          w_idx      = 4'd1;
          w_state    = S_PRE;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_PRE: begin
        if (w_load_ok) begin
          w_tx_byte  = 8'h55;
          w_tx_valid = 1'b1;
          w_idx      = r_idx + 4'd1;
          if (r_idx == 4'd6) begin
            w_state = S_SFD;
          end else begin
            w_state = S_PRE;
          end
        end else begin
          w_state = S_PRE;
        end
      end
      S_SFD: begin
        if (w_load_ok) begin
          w_tx_byte  = 8'hD5;
          w_tx_valid = 1'b1;
          w_idx      = 4'd0;
          w_state    = S_HDR;
        end else begin
          w_state = S_SFD;
        end
      end
      S_HDR: begin
        if (w_load_ok) begin
          w_tx_byte  = w_hdr_byte;
          w_tx_valid = 1'b1;
          w_crc      = crc32_byte(r_crc, w_hdr_byte);
          if (r_idx == 4'd13) begin
            w_pay_cnt = 11'd0;
            w_state   = S_PAY;
          end else begin
            w_idx = r_idx + 4'd1;
          end
        end else begin
          w_state = S_HDR;
        end
      end
      S_PAY: begin
        w_pay_ready = w_load_ok;
        if (w_load_ok && bus.payload_valid) begin
          w_tx_byte  = bus.payload_byte;
          w_tx_valid = 1'b1;
          w_crc      = crc32_byte(r_crc, bus.payload_byte);
          w_pay_cnt  = w_pay_inc;
          // Hitting the maximum without last closes the frame as if last were set.
          if (bus.payload_last || (w_pay_inc == MAX_L)) begin
            w_err   = ~bus.payload_last;
            w_idx   = 4'd0;
            w_state = (w_pay_inc < MIN_L) ? S_PAD : S_FCS;
          end else begin
            w_state = S_PAY;
          end
        end else begin
          w_state = S_PAY;
        end
      end
      S_PAD: begin
        if (w_load_ok) begin
          w_tx_byte  = 8'h00;
          w_tx_valid = 1'b1;
          w_crc      = crc32_byte(r_crc, 8'h00);
          w_pay_cnt  = w_pay_inc;
          if (w_pay_inc == MIN_L) begin
            w_idx   = 4'd0;
            w_state = S_FCS;
          end else begin
            w_state = S_PAD;
          end
        end else begin
          w_state = S_PAD;
        end
      end
      S_FCS: begin
        // idx 4 means all four FCS bytes are loaded and the last one is on the wire.
        if (w_load_ok) begin
          if (r_idx == 4'd4) begin
            w_done    = 1'b1;
            w_ifg_cnt = 8'd0;
            w_state   = S_IFG;
          end else begin
            w_tx_byte  = w_fcs_byte;
            w_tx_valid = 1'b1;
            w_idx      = r_idx + 4'd1;
          end
        end else begin
          w_state = S_FCS;
        end
      end
      S_IFG: begin
        w_crc     = CRC_INIT;
        w_pay_cnt = 11'd0;
        if (r_ifg_cnt == IFG_LAST) begin
          if (bus.payload_valid) begin
            w_tx_byte  = 8'h55;
            w_tx_valid = 1'b1;
            w_idx      = 4'd1;
            w_state    = S_PRE;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_ifg_cnt = r_ifg_cnt + 8'd1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State, datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= 4'd0;
      r_pay_cnt  <= 11'd0;
      r_ifg_cnt  <= 8'd0;
      r_crc      <= CRC_INIT;
      r_tx_byte  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_err      <= 1'b0;
      r_frames   <= 32'd0;
    end else begin
      r_state    <= w_state;
      r_idx      <= w_idx;
      r_pay_cnt  <= w_pay_cnt;
      r_ifg_cnt  <= w_ifg_cnt;
      r_crc      <= w_crc;
      r_tx_byte  <= w_tx_byte;
      r_tx_valid <= w_tx_valid;
      r_err      <= w_err;
      r_frames   <= w_done ? (r_frames + 32'd1) : r_frames;
    end
  end

  assign bus.payload_ready = w_pay_ready;
  assign bus.tx_byte       = r_tx_byte;
  assign bus.tx_valid      = r_tx_valid;
  assign bus.tx_busy       = (r_state != S_IDLE);
  assign bus.frame_done    = w_done;
  assign bus.err_oversize  = r_err;
  assign bus.frames_sent   = r_frames;

endmodule

// File: tb/tb_eth_tx.sv
// Self-checking bench for eth_tx: scoreboard of expected wire bytes, CRC residue
// check on every frame, table-driven frames plus gap/oversize/reset sequences.
module tb_eth_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eth_tx_if bus ();

  eth_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int len;
    int pat;
    bit rand_rdy;
    int wire_len;
  } vec_t;

  int          n_vec = 0;
  int          n_mis = 0;
  logic [7:0]  exp_q[$];
  int          len_q[$];
  int          exp_frames = 0;
  int          n_done = 0;
  int          n_err = 0;
  int          last_gap = -1;
  int          gap_cnt = 0;
  bit          gap_arm = 1'b0;
  int          mon_cnt = 0;
  logic [31:0] mon_crc = 32'hFFFF_FFFF;
  bit          rand_ready = 1'b0;
  bit          stall = 1'b0;
  logic [7:0]  stall_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bit-serial CRC-32 (reflected), data LSB first.
  function automatic logic [31:0] crc_bits(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ d[b];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB8_8320;
    end
    return c;
  endfunction

  function automatic logic [7:0] pbyte(input int pat, input int i);
    case (pat)
      0:       return 8'(i);
      1:       return 8'hAB;
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  task automatic push_expected(input int start, input int n, input int pat);
    logic [111:0] hv;
    logic [31:0]  c;
    logic [7:0]   b;
    int           cnt;
    hv = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h88B5};
    c  = 32'hFFFF_FFFF;
    for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int k = 0; k < 14; k++) begin
      b = hv[111 - 8 * k -: 8];
      exp_q.push_back(b);
      c = crc_bits(c, b);
    end
    for (int k = 0; k < n; k++) begin
      b = pbyte(pat, start + k);
      exp_q.push_back(b);
      c = crc_bits(c, b);
    end
    cnt = n;
    while (cnt < 46) begin
      exp_q.push_back(8'h00);
      c = crc_bits(c, 8'h00);
      cnt++;
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8 * k +: 8]);
  endtask

  task automatic drive_payload(input int start, input int n, input int pat);
    bit acc;
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.payload_valid = 1'b1;
      bus.payload_byte  = pbyte(pat, start + i);
      bus.payload_last  = (i == n - 1);
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 3000) begin
        #4;
        if (bus.payload_ready) acc = 1'b1;
        else begin
          @(negedge clk);
          t++;
        end
      end
      if (!acc) begin
        n_vec++;
        n_mis++;
        $display("FAIL payload_accept_timeout: got no ready for byte %0d required ready", start + i);
        return;
      end
    end
  endtask

  task automatic idle_payload();
    @(negedge clk);
    bus.payload_valid = 1'b0;
    bus.payload_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 5000; t++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0 && !bus.tx_busy) break;
    end
    if (t >= 5000) begin
      n_vec++;
      n_mis++;
      $display("FAIL idle_timeout: got %0d bytes pending required 0", exp_q.size());
    end
    check("frames_sent", bus.frames_sent, 32'(exp_frames));
    check("len_q_drained", 32'(len_q.size()), 32'd0);
  endtask

  // Wire sink: optional pseudo-random back-pressure.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares each transferred byte and checks each frame as eth_rx would.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        mon_cnt = 0;
        mon_crc = 32'hFFFF_FFFF;
        stall   = 1'b0;
        gap_arm = 1'b0;
        continue;
      end
      if (stall) check("stall_hold", {23'd0, bus.tx_valid, bus.tx_byte}, {23'd0, 1'b1, stall_byte});
      stall      = bus.tx_valid && !bus.tx_ready;
      stall_byte = bus.tx_byte;
      if (bus.err_oversize) n_err++;
      if (gap_arm) begin
        if (bus.tx_valid) begin
          last_gap = gap_cnt;
          gap_arm  = 1'b0;
        end else begin
          gap_cnt++;
        end
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL wire_byte: got %h required no byte", bus.tx_byte);
        end else begin
          check("wire_byte", {24'd0, bus.tx_byte}, {24'd0, exp_q.pop_front()});
        end
        if (mon_cnt >= 8) mon_crc = crc_bits(mon_crc, bus.tx_byte);
        mon_cnt++;
      end
      if (bus.frame_done) begin
        n_done++;
        check("crc_ok_residue", mon_crc, 32'hDEBB_20E3);
        if (len_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL wire_len: got %0d required no frame", mon_cnt);
        end else begin
          check("wire_len", 32'(mon_cnt), 32'(len_q.pop_front()));
        end
        mon_cnt = 0;
        mon_crc = 32'hFFFF_FFFF;
        gap_arm = 1'b1;
        gap_cnt = 0;
      end
    end
  end

  initial begin
    vec_t tbl[5];
    int   d0;
    int   e0;
    int   t;

    tbl[0] = '{len: 1,   pat: 1, rand_rdy: 1'b0, wire_len: 72};
    tbl[1] = '{len: 46,  pat: 0, rand_rdy: 1'b0, wire_len: 72};
    tbl[2] = '{len: 100, pat: 2, rand_rdy: 1'b1, wire_len: 126};
    tbl[3] = '{len: 45,  pat: 2, rand_rdy: 1'b0, wire_len: 72};
    tbl[4] = '{len: 47,  pat: 0, rand_rdy: 1'b1, wire_len: 73};

    bus.payload_valid = 1'b0;
    bus.payload_byte  = 8'h00;
    bus.payload_last  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    check("rst_tx_valid",      {31'd0, bus.tx_valid},      32'd0);
    check("rst_tx_byte",       {24'd0, bus.tx_byte},       32'd0);
    check("rst_payload_ready", {31'd0, bus.payload_ready}, 32'd0);
    check("rst_tx_busy",       {31'd0, bus.tx_busy},       32'd0);
    check("rst_frame_done",    {31'd0, bus.frame_done},    32'd0);
    check("rst_err_oversize",  {31'd0, bus.err_oversize},  32'd0);
    check("rst_frames_sent",   bus.frames_sent,            32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      rand_ready = tbl[v].rand_rdy;
      len_q.push_back(tbl[v].wire_len);
      push_expected(0, tbl[v].len, tbl[v].pat);
      drive_payload(0, tbl[v].len, tbl[v].pat);
      idle_payload();
      exp_frames++;
      wait_idle();
      rand_ready = 1'b0;
    end

    // Back-to-back frames: the second waits out exactly the gap.
    d0 = n_done;
    last_gap = -1;
    len_q.push_back(86);
    len_q.push_back(86);
    push_expected(0, 60, 2);
    push_expected(60, 60, 2);
    drive_payload(0, 60, 2);
    drive_payload(60, 60, 2);
    idle_payload();
    exp_frames += 2;
    wait_idle();
    check("ifg_gap", 32'(last_gap), 32'd12);
    check("frame_done_b2b", 32'(n_done - d0), 32'd2);

    // Oversize stream: closes at 1500 bytes, byte 1501 becomes a padded frame.
    e0 = n_err;
    len_q.push_back(1526);
    len_q.push_back(72);
    push_expected(0, 1500, 2);
    push_expected(1500, 1, 2);
    drive_payload(0, 1501, 2);
    idle_payload();
    exp_frames += 2;
    wait_idle();
    check("err_oversize_pulse", 32'(n_err - e0), 32'd1);

    // Reset in the middle of the header, then a fresh frame.
    len_q.push_back(72);
    push_expected(0, 1, 1);
    @(negedge clk);
    bus.payload_valid = 1'b1;
    bus.payload_byte  = 8'hAB;
    bus.payload_last  = 1'b1;
    for (t = 0; t < 200; t++) begin
      @(posedge clk);
      #1;
      if (mon_cnt >= 13) break;
    end
    check("reached_hdr", 32'(mon_cnt), 32'd13);
    rst_n = 1'b0;
    bus.payload_valid = 1'b0;
    bus.payload_last  = 1'b0;
    #1;
    check("rst_mid_tx_valid",      {31'd0, bus.tx_valid},      32'd0);
    check("rst_mid_payload_ready", {31'd0, bus.payload_ready}, 32'd0);
    check("rst_mid_tx_busy",       {31'd0, bus.tx_busy},       32'd0);
    check("rst_mid_frames_sent",   bus.frames_sent,            32'd0);
    exp_q.delete();
    len_q.delete();
    exp_frames = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    len_q.push_back(72);
    push_expected(0, 1, 1);
    drive_payload(0, 1, 1);
    idle_payload();
    exp_frames++;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
